alsu_req_sequencer: RTL
=======================

Name: alsu_req_sequencer

Overview:
Shares one alsu instance between two requesters. Each requester sends a packed command over a valid/ready handshake. A round-robin arbiter picks one command, and the block holds it on the alsu inputs for the alsu's pipeline latency, then captures out/leds. The result returns on the winner's response channel, with backpressure. Commands that the alsu cannot execute are rejected up front, so they never occupy the datapath.

Parameters:
ALSU_LATENCY, 2, number of clock edges from alsu input change to out update (input register plus output register).
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req0_valid  in  1  requester 0 command valid.
req0_ready  out  1  requester 0 command accepted this cycle when valid&&ready.
req0_cmd  in  18  packed command: {opcode[2:0], a[2:0], b[2:0], cin, serial_in, red_op_a, red_op_b, bypass_a, bypass_b, direction, 2'b00 reserved}.
rsp0_valid  out  1  requester 0 response valid.
rsp0_ready  in  1  requester 0 response consumed.
rsp0_data  out  6  captured alsu out.
rsp0_err  out  1  command rejected or alsu flagged invalid.
req1_valid / req1_ready / req1_cmd / rsp1_valid / rsp1_ready / rsp1_data / rsp1_err: same as requester 0, for requester 1.
alsu_a, alsu_b, alsu_opcode  out  3 each  drive alsu.
alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction  out  1 each  drive alsu.
alsu_out  in  6  alsu result.
alsu_leds  in  16  alsu invalid-indication; nonzero = invalid.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all outputs 0, alsu bus = IDLE_CMD (all zero), owner=0.
  - rr pointer favors requester 0.
  - An in-flight command is dropped; no response is produced after release.
- States: IDLE, ISSUE, SAMPLE, RESP.
- IDLE:
  - reqN_ready=1 only for the arbiter grant; at most one ready is high per cycle.
  - The grant is combinational from the valids and the pointer.
  - On accept in cycle N, the block captures cmd and owner.
- Pre-check at accept: opcode in {6,7} with bypass_a=0 and bypass_b=0 is illegal.
  - Goes straight to RESP in cycle N+1 with err=1, data=0.
  - The alsu bus stays IDLE_CMD.
- Legal command:
  - ISSUE for ALSU_LATENCY cycles (N+1..N+ALSU_LATENCY), then SAMPLE for 1 cycle.
  - The alsu bus carries the captured cmd, stable, for all ISSUE+SAMPLE cycles.
  - At the edge ending SAMPLE, the block captures data=alsu_out and err=|alsu_leds.
  - The bus returns to IDLE_CMD in RESP.
- Timing with ALSU_LATENCY=2: rsp_valid first high in cycle N+4.
- RESP:
  - rsp{owner}_valid=1; data and err are held stable until rsp{owner}_ready=1.
  - Then go to IDLE; the next accept is possible in the following cycle, not the same one.
  - The non-owner rsp_valid stays 0.
- Arbitration:
  - RR_EN=1: on a grant, the pointer moves to favor the other requester; with a single valid, that requester wins regardless of the pointer.
  - RR_EN=0: requester 0 wins on a tie.
- No pipelining: one command in flight at a time. req_ready=0 in ISSUE, SAMPLE and RESP.
- Shift opcodes (4/5): the alsu register updates on every edge while the command is held, so rsp_data is whatever the alsu produced. This block performs no data modelling.
- The 2 reserved cmd bits are ignored.

Decomposition:
- Package alsu_seq_pkg holds:
  - CMD_W=18 and the cmd field offsets;
  - the state encoding;
  - IDLE_CMD;
  - the illegal-opcode constants 3'd6 and 3'd7.
- One sub-module: alsu_rr_arbiter, 2-input, with an RR_EN parameter. It produces a one-hot grant and updates its pointer on accept.
- The top level holds the FSM, the command/response registers and the alsu bus.

Test Plan:
1. Reset: hold rst=0 with req0_valid=1.
   -> all outputs 0 and req0_ready=0.
   After release: req0_ready=1 in the first cycle.
2. req0 cmd: opcode=2, a=3, b=5, cin=1 (alsu FULL_ADDER=1), accepted in cycle N.
   -> alsu bus holds this cmd in cycles N+1..N+3.
   -> rsp0_valid=1 at N+4 with data=9, err=0.
   -> rsp1_valid=0 throughout.
3. Both valid in the same cycle: req0 AND a=7,b=5; req1 multiply a=3,b=3.
   -> rsp0 data=5 first, then rsp1 data=9.
   Repeat both -> req0 is granted first again (pointer).
   With RR_EN=0 -> req0 always wins.
4. req1 opcode=6, no bypass.
   -> rsp1_valid at N+1, err=1, data=0; alsu bus stays 0.
   req1 opcode=7 with bypass_a=1, a=4.
   -> normal issue, rsp1 data=4, err=0.
5. req0 red_op_a=1 with opcode=2 (alsu flags leds nonzero).
   -> rsp0_err=1.
   Hold rsp0_ready=0 for 5 cycles with req1_valid=1.
   -> rsp0 data and err stable, req1_ready=0, busy=1.
6. Assert rst=0 during ISSUE.
   -> same cycle: outputs 0, bus IDLE_CMD.
   After release: no response for the dropped command; a new req0 completes normally.

Source files
------------

// File: rtl/alsu_seq_pkg.sv
// alsu_seq_pkg
// Shared definitions for the alsu request sequencer:
//   - CMD_W and the bit offsets of every field in the packed 18-bit command
//   - alsu_cmd_t, the unpacked form of a command as it is driven onto the alsu
//   - state_e, the sequencer FSM encoding
//   - IDLE_CMD, the value the alsu bus carries whenever no command is held
//   - the opcodes the alsu cannot execute without a bypass
package alsu_seq_pkg;

  localparam int CMD_W = 18;

  // Packed command layout, MSB first:
  // {opcode[2:0], a[2:0], b[2:0], cin, serial_in, red_op_a, red_op_b,
  //  bypass_a, bypass_b, direction, 2'b00 reserved}
  localparam int OPC_LSB    = 15;
  localparam int A_LSB      = 12;
  localparam int B_LSB      = 9;
  localparam int CIN_BIT    = 8;
  localparam int SERIAL_BIT = 7;
  localparam int RED_A_BIT  = 6;
  localparam int RED_B_BIT  = 5;
  localparam int BYP_A_BIT  = 4;
  localparam int BYP_B_BIT  = 3;
  localparam int DIR_BIT    = 2;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
    logic       direction;
  } alsu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SAMPLE,
    ST_RESP
  } state_e;

  localparam alsu_cmd_t IDLE_CMD = '0;

  localparam logic [2:0] OPC_ILLEGAL_6 = 3'd6;
  localparam logic [2:0] OPC_ILLEGAL_7 = 3'd7;

  // Reserved bits [1:0] are deliberately dropped here.
  function automatic alsu_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    alsu_cmd_t c;
    c.opcode    = raw[OPC_LSB +: 3];
    c.a         = raw[A_LSB +: 3];
    c.b         = raw[B_LSB +: 3];
    c.cin       = raw[CIN_BIT];
    c.serial_in = raw[SERIAL_BIT];
    c.red_op_a  = raw[RED_A_BIT];
    c.red_op_b  = raw[RED_B_BIT];
    c.bypass_a  = raw[BYP_A_BIT];
    c.bypass_b  = raw[BYP_B_BIT];
    c.direction = raw[DIR_BIT];
    return c;
  endfunction

  // Opcodes 6/7 only make sense when a bypass forwards an operand.
  function automatic logic is_illegal(input alsu_cmd_t c);
    return ((c.opcode == OPC_ILLEGAL_6) || (c.opcode == OPC_ILLEGAL_7)) &&
           !c.bypass_a && !c.bypass_b;
  endfunction

endpackage

// File: rtl/alsu_rr_arbiter.sv
// alsu_rr_arbiter
// Two-input arbiter producing a one-hot grant.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointer returns to requester 0)
//   valid_i  : request valids, bit N = requester N
//   accept_i : the granted request was taken this cycle
//   grant_o  : one-hot grant (all zero when nothing is valid)
// With RR_EN=1 the pointer alternates after each accepted grant; with RR_EN=0
// requester 0 always wins a tie.
module alsu_rr_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // ptr_q = 0 favours requester 0 on a tie, 1 favours requester 1.
  logic ptr_q;
  logic ptr_d;

  // A lone valid wins regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      if (RR_EN && ptr_q) begin
        grant_o = 2'b10;
      end else begin
        grant_o = 2'b01;
      end
    end
  end

  // After a grant is taken the other requester becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (RR_EN && accept_i) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alsu_req_sequencer.sv
// alsu_req_sequencer
// Shares one alsu between two requesters. One command is in flight at a time:
// it is accepted in IDLE, held on the alsu bus through ISSUE (ALSU_LATENCY
// cycles) and SAMPLE (1 cycle), and the alsu result is returned in RESP on the
// winning requester's response channel until that requester takes it.
// Commands using opcode 6/7 without a bypass skip the datapath entirely and
// respond with err=1 one cycle after acceptance.
// Ports:
//   clk, rst                  : clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready/cmd      : command channel of requester N (18-bit packed cmd)
//   rspN_valid/ready/data/err : response channel of requester N
//   alsu_*                    : alsu operand/control bus, and alsu_out/alsu_leds back
//   busy                      : high whenever the FSM is not in IDLE
module alsu_req_sequencer
  import alsu_seq_pkg::*;
#(
  parameter int unsigned ALSU_LATENCY = 2,
  parameter bit          RR_EN        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [5:0]       rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [5:0]       rsp1_data,
  output logic             rsp1_err,
  output logic [2:0]       alsu_a,
  output logic [2:0]       alsu_b,
  output logic [2:0]       alsu_opcode,
  output logic             alsu_cin,
  output logic             alsu_serial_in,
  output logic             alsu_red_op_a,
  output logic             alsu_red_op_b,
  output logic             alsu_bypass_a,
  output logic             alsu_bypass_b,
  output logic             alsu_direction,
  input  logic [5:0]       alsu_out,
  input  logic [15:0]      alsu_leds,
  output logic             busy
);

  localparam int unsigned CNT_W = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALSU_LATENCY - 1);

  state_e           state_q, state_d;
  alsu_cmd_t        cmd_q, cmd_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] latCnt_q, latCnt_d;
  logic [5:0]       rspData_q, rspData_d;
  logic             rspErr_q, rspErr_d;

  logic [1:0] grant;
  logic [1:0] reqReady;
  logic       idleOpen;
  logic       accept;
  alsu_cmd_t  selCmd;
  alsu_cmd_t  busCmd;
  logic       ownerRspReady;
  logic       inResp;

  alsu_rr_arbiter #(
    .RR_EN(RR_EN)
  ) u_arb (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i ({req1_valid, req0_valid}),
    .accept_i(accept),
    .grant_o (grant)
  );

  // rst is folded in so that ready stays low while reset is held, even though
  // the state register already sits in IDLE.
  assign idleOpen   = (state_q == ST_IDLE) && rst;
  assign reqReady   = grant & {2{idleOpen}};
  assign accept     = |reqReady;
  assign req0_ready = reqReady[0];
  assign req1_ready = reqReady[1];

  assign selCmd        = unpack_cmd(grant[1] ? req1_cmd : req0_cmd);
  assign ownerRspReady = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state logic. latCnt counts down the ISSUE cycles so the alsu sees
  // the command for exactly ALSU_LATENCY edges before SAMPLE captures out/leds.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    owner_d   = owner_q;
    latCnt_d  = latCnt_q;
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = selCmd;
          owner_d = grant[1];
          if (is_illegal(selCmd)) begin
            state_d   = ST_RESP;
            rspData_d = '0;
            rspErr_d  = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            latCnt_d = LAT_LAST;
          end
        end
      end
      ST_ISSUE: begin
        if (latCnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          latCnt_d = latCnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        state_d   = ST_RESP;
        rspData_d = alsu_out;
        rspErr_d  = |alsu_leds;
      end
      ST_RESP: begin
        if (ownerRspReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops any in-flight command; nothing about it survives release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= IDLE_CMD;
      owner_q   <= 1'b0;
      latCnt_q  <= '0;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      owner_q   <= owner_d;
      latCnt_q  <= latCnt_d;
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // The alsu only sees a real command while it is being executed; rejected
  // commands never reach it because they jump from IDLE directly to RESP.
  assign busCmd = ((state_q == ST_ISSUE) || (state_q == ST_SAMPLE)) ? cmd_q : IDLE_CMD;

  assign alsu_opcode    = busCmd.opcode;
  assign alsu_a         = busCmd.a;
  assign alsu_b         = busCmd.b;
  assign alsu_cin       = busCmd.cin;
  assign alsu_serial_in = busCmd.serial_in;
  assign alsu_red_op_a  = busCmd.red_op_a;
  assign alsu_red_op_b  = busCmd.red_op_b;
  assign alsu_bypass_a  = busCmd.bypass_a;
  assign alsu_bypass_b  = busCmd.bypass_b;
  assign alsu_direction = busCmd.direction;

  // Only the owner's channel shows the response; the other stays quiet.
  assign inResp     = (state_q == ST_RESP);
  assign rsp0_valid = inResp && !owner_q;
  assign rsp1_valid = inResp && owner_q;
  assign rsp0_data  = rsp0_valid ? rspData_q : '0;
  assign rsp0_err   = rsp0_valid && rspErr_q;
  assign rsp1_data  = rsp1_valid ? rspData_q : '0;
  assign rsp1_err   = rsp1_valid && rspErr_q;

  assign busy = (state_q != ST_IDLE);

endmodule
